// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: one FSM walks FETCH..WB over a shared ALU and regfile,
// using a single req/ack memory port that tolerates wait states.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned SEG_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [SEG_W-1:0] seg,
  output logic [31:0]      pc_out,
  output logic [31:0]      instret,
  output logic             halted,
  output logic [1:0]       err
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ADDIEX, S_ALUWB, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  state_t state_reg, state_next;

  logic [31:0] pc_reg, pc_next;
  logic [31:0] ir_reg, mdr_reg, a_reg, b_reg;
  logic [31:0] alu_reg, alu_next, alu_result;
  logic [31:0] rf [32];

  logic             req_reg, req_next, we_reg, we_next;
  logic [31:0]      addr_reg, addr_next, wdata_reg, wdata_next;
  logic [SEG_W-1:0] seg_reg, seg_next;
  logic [31:0]      instret_reg, instret_next;
  logic             halted_reg, halted_next;
  logic [1:0]       err_reg, err_next;
  logic [31:0]      wait_cnt_reg, wait_cnt_next;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic        funct_ok, op_legal, ack_ok, timeout_hit;

  assign op       = ir_reg[31:26];
  assign rs       = ir_reg[25:21];
  assign rt       = ir_reg[20:16];
  assign rd       = ir_reg[15:11];
  assign funct    = ir_reg[5:0];
  assign imm_sext = {{16{ir_reg[15]}}, ir_reg[15:0]};

  assign funct_ok = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  assign op_legal = (op == OP_RTYPE) ? funct_ok
                  : (op inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_HALT});
  // An ack only counts while a request is actually outstanding.
  assign ack_ok      = req_reg && mem_ack;
  assign timeout_hit = (TIMEOUT != 0) && req_reg && !mem_ack && (wait_cnt_reg == TIMEOUT - 1);

  always_comb begin
    alu_result = '0;
    case (funct)
      6'h20:   alu_result = a_reg + b_reg;
      6'h22:   alu_result = a_reg - b_reg;
      6'h24:   alu_result = a_reg & b_reg;
      6'h25:   alu_result = a_reg | b_reg;
      6'h2A:   alu_result = ($signed(a_reg) < $signed(b_reg)) ? 32'd1 : 32'd0;
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_FETCH;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  if (ack_ok) state_next = S_DECODE;
                else if (timeout_hit) state_next = S_HALT;
      S_DECODE: begin
        if (!op_legal) state_next = S_HALT;
        else begin
          case (op)
            OP_RTYPE:     state_next = S_EXEC;
            OP_ADDI:      state_next = S_ADDIEX;
            OP_LW, OP_SW: state_next = S_MEMADR;
            OP_BEQ:       state_next = S_BRANCH;
            OP_J:         state_next = S_JUMP;
            default:      state_next = S_HALT;
          endcase
        end
      end
      S_EXEC, S_ADDIEX: state_next = S_ALUWB;
      S_MEMADR: state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (ack_ok) state_next = S_MEMWB;
                else if (timeout_hit) state_next = S_HALT;
      S_MEMWR:  if (ack_ok) state_next = S_FETCH;
                else if (timeout_hit) state_next = S_HALT;
      S_ALUWB, S_MEMWB, S_BRANCH, S_JUMP: state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_HALT;
    endcase
  end

  always_comb begin
    pc_next       = pc_reg;
    alu_next      = alu_reg;
    seg_next      = seg_reg;
    instret_next  = instret_reg;
    err_next      = err_reg;
    rf_we         = 1'b0;
    rf_waddr      = rt;
    rf_wdata      = alu_reg;
    wait_cnt_next = (req_reg && !mem_ack) ? wait_cnt_reg + 32'd1 : '0;
    case (state_reg)
      S_FETCH:  if (ack_ok) pc_next = pc_reg + 32'd4;
                else if (timeout_hit) err_next = 2'd2;
      S_DECODE: if (!op_legal) err_next = 2'd1;
      S_EXEC:   alu_next = alu_result;
      S_ADDIEX: alu_next = a_reg + imm_sext;
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = (op == OP_RTYPE) ? rd : rt;
      end
      S_MEMRD:  if (timeout_hit) err_next = 2'd2;
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_reg;
      end
      S_MEMWR:  if (ack_ok) instret_next = instret_reg + 32'd1;
                else if (timeout_hit) err_next = 2'd2;
      S_BRANCH: begin
        instret_next = instret_reg + 32'd1;
        if (a_reg == b_reg) pc_next = pc_reg + (imm_sext << 2);
      end
      S_JUMP: begin
        instret_next = instret_reg + 32'd1;
        pc_next      = {pc_reg[31:28], ir_reg[25:0], 2'b00};
      end
      default: ;
    endcase
    // seg mirrors the write data even when $0 swallows the write.
    if (rf_we) begin
      seg_next     = rf_wdata[SEG_W-1:0];
      instret_next = instret_reg + 32'd1;
    end
    // Bus outputs are set up on entry to a memory state and held until the ack.
    req_next    = state_next inside {S_FETCH, S_MEMRD, S_MEMWR};
    we_next     = (state_next == S_MEMWR);
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    if (state_next == S_FETCH)
      addr_next = pc_next & 32'hFFFF_FFFC;
    else if (state_next inside {S_MEMRD, S_MEMWR})
      addr_next = (a_reg + imm_sext) & 32'hFFFF_FFFC;
    if (state_next == S_MEMWR) wdata_next = b_reg;
    halted_next = (state_next == S_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
      if (state_reg == S_DECODE) begin
        a_reg <= rf[rs];
        b_reg <= rf[rt];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg       <= RESET_PC;
      ir_reg       <= '0;
      mdr_reg      <= '0;
      alu_reg      <= '0;
      req_reg      <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      seg_reg      <= '0;
      instret_reg  <= '0;
      halted_reg   <= 1'b0;
      err_reg      <= '0;
      wait_cnt_reg <= '0;
    end else begin
      if (state_reg == S_FETCH && ack_ok) ir_reg  <= mem_rdata;
      if (state_reg == S_MEMRD && ack_ok) mdr_reg <= mem_rdata;
      pc_reg       <= pc_next;
      alu_reg      <= alu_next;
      req_reg      <= req_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      seg_reg      <= seg_next;
      instret_reg  <= instret_next;
      halted_reg   <= halted_next;
      err_reg      <= err_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  assign mem_req   = req_reg;
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign seg       = seg_reg;
  assign pc_out    = pc_reg;
  assign instret   = instret_reg;
  assign halted    = halted_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: an ISA-level model predicts every bus transaction and the
// final architectural outputs; a wait-state memory responder and a monitor check the core.
module tb_mips_multicycle_core;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          TO  = 255;

  logic        clk, rst;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [6:0]  seg;
  logic [31:0] pc_out, instret;
  logic        halted;
  logic [1:0]  err;

  mips_multicycle_core #(.RESET_PC(RPC), .TIMEOUT(TO), .SEG_W(7)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .seg(seg), .pc_out(pc_out), .instret(instret), .halted(halted), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] prog [256];
  logic [31:0] mem  [256];
  logic [5:0]  fns  [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  int          errors = 0;
  int          checks = 0;
  int          exp_instret;
  logic [6:0]  exp_seg;
  logic [31:0] exp_pc;
  logic [1:0]  exp_err;

  int stall_idx = -1;
  int stall_cycles = 0;
  int max_wait = 3;
  int txn_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int target);
    return {6'h02, 26'(target)};
  endfunction

  // ISA-level reference: executes the program image instruction by instruction,
  // queueing every bus transaction the core should make. 'stall' names the
  // transaction the memory never acknowledges (-1 = none).
  task automatic model_run(input int stall);
    logic [31:0] r [32];
    logic [31:0] mm [256];
    logic [31:0] pc, inst, a, b, simm, ea, res;
    logic [5:0]  op, fn;
    txn_t        t;
    int          n, dst;
    bit          done, wr;
    for (int i = 0; i < 32; i++) r[i] = '0;
    mm = prog;
    pc = RPC;
    n = 0;
    done = 0;
    exp_instret = 0;
    exp_seg = '0;
    exp_err = 2'd0;
    for (int step = 0; step < 1000 && !done; step++) begin
      if (n == stall) begin exp_err = 2'd2; break; end
      t = '{we: 1'b0, addr: pc, wdata: 32'h0};
      exp_q.push_back(t);
      n++;
      inst = mm[pc[9:2]];
      pc   = pc + 32'd4;
      op   = inst[31:26];
      fn   = inst[5:0];
      a    = r[inst[25:21]];
      b    = r[inst[20:16]];
      simm = {{16{inst[15]}}, inst[15:0]};
      ea   = a + simm;
      wr   = 0;
      dst  = 0;
      res  = '0;
      case (op)
        6'h00: begin
          wr  = 1;
          dst = int'(inst[15:11]);
          case (fn)
            6'h20:   res = a + b;
            6'h22:   res = a - b;
            6'h24:   res = a & b;
            6'h25:   res = a | b;
            6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: begin wr = 0; exp_err = 2'd1; done = 1; end
          endcase
        end
        6'h08: begin wr = 1; dst = int'(inst[20:16]); res = ea; end
        6'h23: begin
          if (n == stall) begin exp_err = 2'd2; done = 1; end
          else begin
            t = '{we: 1'b0, addr: ea & 32'hFFFF_FFFC, wdata: 32'h0};
            exp_q.push_back(t);
            n++;
            wr  = 1;
            dst = int'(inst[20:16]);
            res = mm[ea[9:2]];
          end
        end
        6'h2B: begin
          if (n == stall) begin exp_err = 2'd2; done = 1; end
          else begin
            t = '{we: 1'b1, addr: ea & 32'hFFFF_FFFC, wdata: b};
            exp_q.push_back(t);
            n++;
            mm[ea[9:2]] = b;
            exp_instret++;
          end
        end
        6'h04: begin
          if (a == b) pc = pc + (simm << 2);
          exp_instret++;
        end
        6'h02: begin
          pc = {pc[31:28], inst[25:0], 2'b00};
          exp_instret++;
        end
        6'h3F:   done = 1;
        default: begin exp_err = 2'd1; done = 1; end
      endcase
      if (wr) begin
        exp_seg = res[6:0];
        if (dst != 0) r[dst] = res;
        exp_instret++;
      end
    end
    exp_pc = pc;
  endtask

  // Random straight-line program with forward-only branches/jumps, an epilogue
  // that stores $1..$7, and a final halt or illegal instruction.
  task automatic gen_random(input int n_body, input bit end_illegal);
    int rs, rt, rd, k;
    for (int i = 0; i < 256; i++) prog[i] = $urandom;
    for (int i = 0; i < n_body; i++) begin
      rs = $urandom_range(0, 7);
      rt = $urandom_range(0, 7);
      rd = $urandom_range(0, 7);
      k  = $urandom_range(0, 9);
      if (k <= 3)      prog[i] = enc_r(rs, rt, rd, fns[$urandom_range(0, 4)]);
      else if (k <= 5) prog[i] = enc_i(6'h08, rs, rt, int'($urandom_range(0, 65535)));
      else if (k == 6) prog[i] = enc_i(6'h23, 0, rt, int'(32'h200 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3)));
      else if (k == 7) prog[i] = enc_i(6'h2B, 0, rt, int'(32'h200 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3)));
      else if (k == 8) prog[i] = enc_i(6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : rt, int'($urandom_range(0, 3)));
      else             prog[i] = enc_j(i + 1 + int'($urandom_range(0, 3)));
    end
    for (int r = 1; r < 8; r++) prog[n_body + r - 1] = enc_i(6'h2B, 0, r, 32'h300 + 4 * r);
    if (!end_illegal)                   prog[n_body + 7] = 32'hFC00_0000;
    else if ($urandom_range(0, 1) == 1) prog[n_body + 7] = enc_i(6'h11, 1, 2, 3);
    else                                prog[n_body + 7] = enc_r(1, 2, 3, 6'h21);
  endtask

  task automatic hold_reset(input int stall);
    rst = 1'b0;
    exp_q.delete();
    stall_idx = stall;
    stall_cycles = 0;
    mem = prog;
    model_run(stall);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic finish_episode();
    int cyc = 0;
    while (!halted && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("err", 32'(err), 32'(exp_err));
    chk("instret", instret, 32'(exp_instret));
    chk("seg", 32'(seg), 32'(exp_seg));
    chk("pc_out", pc_out, exp_pc);
    chk("req_low_halted", 32'(mem_req), 32'd0);
    if (exp_err == 2'd2) chk("timeout_cycles", 32'(stall_cycles), 32'(TO));
  endtask

  // Memory: random 0..max_wait wait states per transaction, stray acks while idle.
  int cur_idx, cnt, delay, txn_idx;
  bit in_txn, completing;
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    in_txn = 0;
    completing = 0;
    txn_idx = 0;
    cur_idx = -2;
    cnt = 0;
    delay = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_txn = 0;
        completing = 0;
        txn_idx = 0;
        mem_ack = 1'b0;
      end else begin
        if (completing) in_txn = 0;
        completing = 0;
        mem_ack = 1'b0;
        if (mem_req) begin
          if (!in_txn) begin
            in_txn = 1;
            cnt = 0;
            delay = $urandom_range(0, max_wait);
            cur_idx = txn_idx;
            txn_idx++;
          end
          if (cur_idx == stall_idx) stall_cycles++;
          else if (cnt == delay) begin
            mem_ack = 1'b1;
            completing = 1;
            mem_rdata = mem[mem_addr[9:2]];
            if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
          end else cnt++;
        end else begin
          in_txn = 0;
          if ($urandom_range(0, 7) == 0) begin
            mem_ack = 1'b1;
            mem_rdata = $urandom;
          end
        end
      end
    end
  end

  // Monitor: checks request stability while waiting and pops the scoreboard on each ack.
  bit          mon_active = 0;
  logic        hold_we;
  logic [31:0] hold_addr, hold_wdata;
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      #1;
      if (rst && mem_req) begin
        if (!mon_active) begin
          mon_active = 1;
          hold_we = mem_we;
          hold_addr = mem_addr;
          hold_wdata = mem_wdata;
        end else begin
          chk("req_stable_addr", mem_addr, hold_addr);
          chk("req_stable_ctl", {31'd0, mem_we} ^ (mem_we ? mem_wdata ^ hold_wdata : 32'd0), {31'd0, hold_we});
        end
        if (mem_ack) begin
          mon_active = 0;
          txn_count++;
          $display("txn %0d: %s addr=%h data=%h", txn_count, mem_we ? "wr" : "rd", mem_addr,
                   mem_we ? mem_wdata : mem_rdata);
          if (exp_q.size() == 0) chk("txn_unexpected", 32'd1, 32'd0);
          else begin
            t = exp_q.pop_front();
            chk("txn_we", 32'(mem_we), 32'(t.we));
            chk("txn_addr", mem_addr, t.addr);
            if (t.we) chk("txn_wdata", mem_wdata, t.wdata);
          end
        end
      end else mon_active = 0;
    end
  end

  initial begin
    int n;
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_seg", 32'(seg), 32'd0);
    chk("rst_pc", pc_out, RPC);
    chk("rst_instret", instret, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Directed: arithmetic, $0 target, load/store, taken beq and a jump.
    for (int i = 0; i < 256; i++) prog[i] = '0;
    prog[0]  = enc_i(6'h08, 0, 1, 5);
    prog[1]  = enc_i(6'h08, 0, 2, -3);
    prog[2]  = enc_r(1, 2, 3, 6'h20);
    prog[3]  = enc_i(6'h2B, 0, 3, 32'h40);
    prog[4]  = enc_i(6'h23, 0, 4, 32'h40);
    prog[5]  = enc_r(2, 1, 5, 6'h2A);
    prog[6]  = enc_r(2, 1, 6, 6'h22);
    prog[7]  = enc_i(6'h08, 0, 0, 9);
    prog[8]  = enc_i(6'h04, 1, 1, 1);
    prog[9]  = enc_i(6'h11, 0, 0, 0);
    prog[10] = enc_j(32'hC);
    prog[11] = 32'hFC00_0000;
    prog[12] = enc_i(6'h2B, 0, 5, 32'h44);
    prog[13] = enc_i(6'h2B, 0, 6, 32'h48);
    prog[14] = enc_i(6'h2B, 0, 4, 32'h4C);
    prog[15] = 32'hFC00_0000;
    hold_reset(-1);
    finish_episode();
    chk("dir_mem40", mem[16], 32'h0000_0002);
    chk("dir_slt", mem[17], 32'h0000_0001);
    chk("dir_sub", mem[18], 32'hFFFF_FFF8);
    chk("dir_lw", mem[19], 32'h0000_0002);
    chk("dir_instret", instret, 32'd13);
    chk("dir_seg", 32'(seg), 32'h09);
    chk("dir_pc", pc_out, 32'h40);
    chk("dir_err", 32'(err), 32'd0);

    // Directed illegal opcode: one retired addi, then op 0x11 traps.
    for (int i = 0; i < 256; i++) prog[i] = '0;
    prog[0] = enc_i(6'h08, 0, 1, 1);
    prog[1] = enc_i(6'h11, 0, 0, 0);
    hold_reset(-1);
    finish_episode();
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_instret", instret, 32'd1);

    for (int e = 0; e < 6; e++) begin
      gen_random(int'($urandom_range(10, 30)), 1'b0);
      hold_reset(-1);
      finish_episode();
    end
    for (int e = 0; e < 3; e++) begin
      gen_random(int'($urandom_range(5, 20)), 1'b1);
      hold_reset(-1);
      finish_episode();
    end

    // Bus timeouts: first fetch, then a random later transaction.
    gen_random(12, 1'b0);
    hold_reset(0);
    finish_episode();
    chk("to_first_err", 32'(err), 32'd2);
    gen_random(20, 1'b0);
    hold_reset(int'($urandom_range(3, 20)));
    finish_episode();

    // Reset asserted while a load waits for its ack, then a clean rerun.
    for (int i = 0; i < 256; i++) prog[i] = '0;
    prog[0] = enc_i(6'h08, 0, 1, 7);
    prog[1] = enc_i(6'h23, 0, 2, 32'h204);
    prog[2] = enc_i(6'h2B, 0, 2, 32'h300);
    prog[3] = 32'hFC00_0000;
    prog[129] = 32'h1234_5678;
    hold_reset(2);
    n = 0;
    while (stall_cycles < 5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    #2;
    chk("mid_stalled", 32'(stall_cycles >= 5), 32'd1);
    chk("mid_req_high", 32'(mem_req), 32'd1);
    chk("mid_instret", instret, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_pc", pc_out, RPC);
    chk("mid_rst_instret", instret, 32'd0);
    chk("mid_rst_seg", 32'(seg), 32'd0);
    hold_reset(-1);
    finish_episode();
    chk("mid_rerun_store", mem[192], 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
